video_dma_engine: RTL

VIDEO_DMA_ENGINE -- requirements
Module: video_dma_engine

---
 rtl/video_dma_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/video_dma_engine.sv
// Descriptor-driven DMA: reads a linear source region over AXI4 read bursts and
// writes each returned beat into a word-addressed video memory.
module video_dma_engine #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int VM_AW      = 15,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ADDR_WIDTH-1:0] desc_src,
    input  logic [VM_AW-1:0]      desc_dst,
    input  logic [LEN_WIDTH-1:0]  desc_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  vm_we,
    output logic [VM_AW-1:0]      vm_addr,
    output logic [DATA_WIDTH-1:0] vm_wdata
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int CW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

    // Every channel (desc, AR, R) transfers on a cycle where valid && ready are
    // both high at the rising edge; valid never waits for ready, and the payload
    // stays stable while valid is high and ready is low.
    typedef enum logic [1:0] {IDLE, ISSUE_AR, WAIT_R, DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [VM_AW-1:0]      dst_addr;
    logic [LEN_WIDTH-1:0]  rem;
    logic [LEN_WIDTH-1:0]  rem_dec;
    logic [8:0]            burst_len;
    logic [8:0]            beat_cnt;
    logic [8:0]            beat_nx;
    logic                  err_q;
    logic                  done_phase;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  proto_err;
    logic                  beat_err;
    logic [ADDR_WIDTH-1:0] src_aligned;

    // Burst = min(remaining beats, MAX_BURST, beats left in the current 4 KiB page).
    function automatic logic [8:0] calc_burst(input logic [11:0] page_off,
                                              input logic [LEN_WIDTH-1:0] left);
        logic [12:0]   to_4k;
        logic [CW-1:0] lim;
        to_4k = (13'h1000 - {1'b0, page_off}) >> SZ;
        lim   = CW'(to_4k);
        if (lim > CW'(MAX_BURST)) lim = CW'(MAX_BURST);
        if (CW'(left) < lim) lim = CW'(left);
        return 9'(lim);
    endfunction

    assign src_aligned = desc_src & ~ADDR_WIDTH'(BYTES - 1);
    assign ar_hs       = (state == ISSUE_AR) && arready;
    assign r_hs        = (state == WAIT_R) && rvalid;
    assign beat_nx     = beat_cnt + 9'd1;
    assign rem_dec     = (rem == '0) ? '0 : rem - LEN_WIDTH'(1);
    // rlast must land exactly on the computed burst length; early or late is an error.
    assign proto_err   = rlast ? (beat_nx != burst_len) : (beat_nx >= burst_len);
    assign beat_err    = (rresp != 2'b00) || proto_err;

    assign araddr  = cur_addr;
    assign arlen   = 8'(burst_len - 9'd1);
    assign arsize  = 3'(SZ);
    assign arburst = 2'b01;
    assign err     = err_q;

    always_comb begin
        state_nx   = state;
        desc_ready = 1'b0;
        busy       = 1'b1;
        arvalid    = 1'b0;
        rready     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                desc_ready = 1'b1;
                busy       = 1'b0;
                if (desc_valid) state_nx = (desc_len == '0) ? DONE : ISSUE_AR;
            end
            ISSUE_AR: begin
                arvalid = 1'b1;
                if (arready) state_nx = WAIT_R;
            end
            WAIT_R: begin
                rready = 1'b1;
                if (rvalid && rlast)
                    state_nx = (err_q || beat_err || rem_dec == '0) ? DONE : ISSUE_AR;
            end
            DONE: begin
                // First DONE cycle lets the final write land; done pulses on the second.
                done = done_phase;
                if (done_phase) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_addr   <= '0;
            dst_addr   <= '0;
            rem        <= '0;
            burst_len  <= 9'd1;
            beat_cnt   <= '0;
            err_q      <= 1'b0;
            done_phase <= 1'b0;
            vm_we      <= 1'b0;
            vm_addr    <= '0;
            vm_wdata   <= '0;
        end else begin
            state      <= state_nx;
            vm_we      <= r_hs;
            done_phase <= (state == DONE) && !done_phase;
            if (state == IDLE && desc_valid) begin
                cur_addr <= src_aligned;
                dst_addr <= desc_dst;
                rem      <= desc_len;
                err_q    <= 1'b0;
                if (desc_len != '0) burst_len <= calc_burst(src_aligned[11:0], desc_len);
            end
            if (ar_hs) begin
                cur_addr <= cur_addr + (ADDR_WIDTH'(burst_len) << SZ);
                beat_cnt <= '0;
            end
            if (r_hs) begin
                vm_addr  <= dst_addr;
                vm_wdata <= rdata;
                dst_addr <= dst_addr + VM_AW'(1);
                rem      <= rem_dec;
                beat_cnt <= beat_nx;
                if (beat_err) err_q <= 1'b1;
                if (rlast && state_nx == ISSUE_AR)
                    burst_len <= calc_burst(cur_addr[11:0], rem_dec);
            end
        end
    end

endmodule
